// File: rtl/layer_pkg.sv
// layer_pkg: shared pixel types, fixed colours, flash FSM states and the
// 16-entry palette used by layer_compositor.
package layer_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLASH = 2'd2
  } flash_state_e;

  localparam rgb_t SKY_RGB        = '{r: 8'h3F, g: 8'hBF, b: 8'hFF};
  localparam rgb_t FLASH_HIT_RGB  = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t FLASH_MISS_RGB = '{r: 8'h00, g: 8'h00, b: 8'h00};

  // Entry 0 is never displayed: index 0 means transparent.
  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'h000000, 24'hFFFFFF, 24'h7C3F00,
    24'hE45C10, 24'h00A800, 24'h0058F8, 24'hA81000,
    24'hF8B800, 24'hBCBCBC, 24'h7C7C7C, 24'hFCE0A8,
    24'h3CBCFC, 24'h503000, 24'hD82800, 24'hF878F8
  };

  function automatic rgb_t pal_lookup(input logic [3:0] index);
    return rgb_t'(PALETTE[index]);
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// layer_priority_enc: combinational fixed-priority resolve of sprite layers;
// layer 0 wins, a palette index of 0 is transparent and falls through.
module layer_priority_enc #(
  parameter int N_LAYERS = 4,
  parameter int PAL_W    = 4,
  parameter int SEL_W    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic [N_LAYERS-1:0]       i_on,
  input  logic [N_LAYERS*PAL_W-1:0] i_idx,
  output logic                      o_hit,
  output logic [PAL_W-1:0]          o_idx,
  output logic [SEL_W-1:0]          o_sel
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    o_sel = '0;
    // Walk from lowest to highest priority so the last match written wins.
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (i_on[k] && (i_idx[k*PAL_W +: PAL_W] != '0)) begin
        o_hit = 1'b1;
        o_idx = i_idx[k*PAL_W +: PAL_W];
        o_sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: 2-stage pixel compositor (layer resolve, colour) with a
// shot-flash FSM. Optional dusk gradient background via `GRADIENT_BG_EN.
module layer_compositor
  import layer_pkg::*;
#(
  parameter int N_LAYERS     = 4,
  parameter int PAL_W        = 4,
  parameter int FLASH_FRAMES = 2
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank_n,
  input  logic                      frame_start,
  input  logic [N_LAYERS-1:0]       layer_on,
  input  logic [N_LAYERS*PAL_W-1:0] layer_idx,
  input  logic [N_LAYERS-1:0]       target_mask,
  input  logic                      shot,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      flash_active
);

  localparam int SEL_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  flash_state_e r_state, w_state_next;
  logic [3:0]   r_cnt, w_cnt_next;
  logic         r_flash_active;

  logic             w_hit;
  logic [PAL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_sel;

  logic             r_s1_hit, r_s1_tgt, r_s1_flash, r_s1_blank_n;
  logic [PAL_W-1:0] r_s1_idx;
  rgb_t             w_bg, w_rgb, r_rgb;

`ifdef GRADIENT_BG_EN
  logic [6:0] r_s1_x;
  logic       w_unused_in;
  assign w_unused_in = ^{DrawX[2:0], DrawY};
`else
  logic       w_unused_in;
  assign w_unused_in = ^{DrawX, DrawY};
`endif

  layer_priority_enc #(.N_LAYERS(N_LAYERS), .PAL_W(PAL_W), .SEL_W(SEL_W)) u_prio (
    .i_on  (layer_on),
    .i_idx (layer_idx),
    .o_hit (w_hit),
    .o_idx (w_idx),
    .o_sel (w_sel)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE:  if (shot) w_state_next = ARMED;
      ARMED: if (frame_start) begin
        w_state_next = FLASH;
        w_cnt_next   = 4'(FLASH_FRAMES - 1);
      end
      FLASH: if (frame_start) begin
        if (r_cnt == 4'd0) w_state_next = IDLE;
        else               w_cnt_next   = r_cnt - 4'd1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Stage 1 samples the next flash state so a frame_start edge takes effect
  // from that frame's first pixel.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_flash_active <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_flash_active <= (w_state_next == FLASH);
    end
  end

  // NOTE: pipeline registers are reset so no stale pixel leaks after reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_hit     <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_tgt     <= 1'b0;
      r_s1_flash   <= 1'b0;
      r_s1_blank_n <= 1'b0;
`ifdef GRADIENT_BG_EN
      r_s1_x       <= '0;
`endif
    end else begin
      r_s1_hit     <= w_hit;
      r_s1_idx     <= w_idx;
      r_s1_tgt     <= w_hit & target_mask[w_sel];
      r_s1_flash   <= (w_state_next == FLASH);
      r_s1_blank_n <= blank_n;
`ifdef GRADIENT_BG_EN
      r_s1_x       <= DrawX[9:3];
`endif
    end
  end

  always_comb begin
`ifdef GRADIENT_BG_EN
    w_bg = '{r: 8'h3F, g: 8'h00, b: 8'h7F - {1'b0, r_s1_x}};
`else
    w_bg = SKY_RGB;
`endif
    if (!r_s1_blank_n)   w_rgb = FLASH_MISS_RGB;
    else if (r_s1_flash) w_rgb = (r_s1_hit && r_s1_tgt) ? FLASH_HIT_RGB : FLASH_MISS_RGB;
    else if (r_s1_hit)   w_rgb = pal_lookup(4'(r_s1_idx));
    else                 w_rgb = w_bg;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_rgb <= '0;
    else          r_rgb <= w_rgb;
  end

  assign VGA_R        = r_rgb.r;
  assign VGA_G        = r_rgb.g;
  assign VGA_B        = r_rgb.b;
  assign flash_active = r_flash_active;

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed scoreboard bench; each pixel's expected RGB is
// queued when driven and compared when it leaves the 2-cycle pipeline.
module tb_layer_compositor;
  import layer_pkg::*;

  localparam int NL = 4;
  localparam int PW = 4;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b1;
  logic [9:0]       DrawX = '0, DrawY = '0;
  logic             blank_n = 1'b0, frame_start = 1'b0, shot = 1'b0;
  logic [NL-1:0]    layer_on = '0, target_mask = '0;
  logic [NL*PW-1:0] layer_idx = '0;
  logic [7:0]       VGA_R, VGA_G, VGA_B;
  logic             flash_active;

  int checks = 0;
  int errors = 0;

  rgb_t  sb_exp[$];
  string sb_tag[$];
  logic  prev_fl = 1'b0;

  logic       g_blank = 1'b1;
  logic [3:0] g_mask  = 4'b0001;
  logic [9:0] g_x     = '0;

  rgb_t pal [16] = '{
    24'h000000, 24'h000000, 24'hFFFFFF, 24'h7C3F00,
    24'hE45C10, 24'h00A800, 24'h0058F8, 24'hA81000,
    24'hF8B800, 24'hBCBCBC, 24'h7C7C7C, 24'hFCE0A8,
    24'h3CBCFC, 24'h503000, 24'hD82800, 24'hF878F8
  };

  layer_compositor dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank_n      (blank_n),
    .frame_start  (frame_start),
    .layer_on     (layer_on),
    .layer_idx    (layer_idx),
    .target_mask  (target_mask),
    .shot         (shot),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .flash_active (flash_active)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic rgb_t bg(input logic [9:0] x);
`ifdef GRADIENT_BG_EN
    return '{r: 8'h3F, g: 8'h00, b: 8'h7F - {1'b0, x[9:3]}};
`else
    return '{r: 8'h3F, g: 8'hBF, b: 8'hFF};
`endif
  endfunction

  function automatic rgb_t model(input logic bl, input logic [3:0] on, input logic [15:0] idx,
                                 input logic [3:0] mask, input logic [9:0] x, input logic fl);
    logic       hit = 1'b0;
    logic [3:0] win = '0;
    logic       tgt = 1'b0;
    for (int k = 0; k < NL; k++) begin
      if (!hit && on[k] && idx[k*4 +: 4] != 4'd0) begin
        hit = 1'b1;
        win = idx[k*4 +: 4];
        tgt = mask[k];
      end
    end
    if (!bl) return '0;
    if (fl)  return (hit && tgt) ? 24'hFFFFFF : 24'h000000;
    if (hit) return pal[win];
    return bg(x);
  endfunction

  // One pixel per call: check the pixel driven two calls ago, then drive a new one.
  task automatic step(input logic [3:0] on, input logic [15:0] idx, input logic fs,
                      input logic sh, input logic fl, input string tag);
    @(negedge Clk);
    if (sb_exp.size() == 2) check(sb_tag.pop_front(), {VGA_R, VGA_G, VGA_B}, sb_exp.pop_front());
    check({tag, " flash_active"}, flash_active, prev_fl);
    blank_n     = g_blank;
    target_mask = g_mask;
    DrawX       = g_x;
    layer_on    = on;
    layer_idx   = idx;
    frame_start = fs;
    shot        = sh;
    sb_exp.push_back(model(g_blank, on, idx, g_mask, g_x, fl));
    sb_tag.push_back(tag);
    prev_fl = fl;
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    #1;
    check("reset rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    check("reset flash_active", flash_active, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Priority, transparency, blanking, background.
    step(4'b0000, 16'h0000, 0, 0, 0, "sky");
    step(4'b0011, 16'h0050, 0, 0, 0, "l0 transparent -> pal5");
    step(4'b0011, 16'h0053, 0, 0, 0, "l0 wins pal3");
    step(4'b1000, 16'h9000, 0, 0, 0, "l3 only pal9");
    step(4'b0100, 16'h9000, 0, 0, 0, "all transparent -> bg");
    step(4'b1111, 16'hF700, 0, 0, 0, "l2 first opaque pal7");
    g_blank = 1'b0;
    step(4'b0001, 16'h0002, 0, 0, 0, "blanked hit");
    g_blank = 1'b1;
    g_x = 10'd639;
    step(4'b0000, 16'h0000, 0, 0, 0, "bg x639");
    g_x = 10'd8;
    step(4'b0000, 16'h0000, 0, 0, 0, "bg x8");
    g_x = 10'd0;

    // Shot mid-frame: armed until the next frame_start, then 2 frames of flash.
    step(4'b0001, 16'h0003, 1, 0, 0, "frame0 start");
    step(4'b0000, 16'h0000, 0, 0, 0, "frame0 px");
    step(4'b0000, 16'h0000, 0, 1, 0, "shot mid-frame");
    step(4'b0001, 16'h0003, 0, 0, 0, "armed px");
    step(4'b0000, 16'h0000, 0, 0, 0, "armed px2");
    step(4'b0001, 16'h0003, 1, 0, 1, "flash1 target white");
    step(4'b0010, 16'h0050, 0, 0, 1, "flash1 non-target black");
    step(4'b0000, 16'h0000, 0, 0, 1, "flash1 bg black");
    step(4'b0000, 16'h0000, 0, 1, 1, "second shot ignored");
    step(4'b0011, 16'h0040, 0, 0, 1, "flash1 l1 via transparent l0");
    g_blank = 1'b0;
    step(4'b0001, 16'h0003, 0, 0, 1, "flash blanked");
    g_blank = 1'b1;
    step(4'b0001, 16'h0003, 1, 0, 1, "flash2 target white");
    step(4'b0000, 16'h0000, 0, 0, 1, "flash2 bg black");
    step(4'b0001, 16'h0003, 1, 0, 0, "frame3 normal");
    step(4'b0000, 16'h0000, 0, 0, 0, "frame3 px");
    step(4'b0001, 16'h0003, 1, 0, 0, "frame4 no queued flash");

    // Shot together with frame_start in IDLE arms only.
    step(4'b0001, 16'h0003, 1, 1, 0, "shot+fs idle");
    step(4'b0001, 16'h0003, 0, 0, 0, "armed after shot+fs");
    step(4'b0001, 16'h0003, 1, 0, 1, "late flash white");
    step(4'b0000, 16'h0000, 0, 0, 1, "late flash bg");

    // Reset in the middle of a flash.
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("midflash reset rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    check("midflash reset flash_active", flash_active, 1'b0);
    sb_exp.delete();
    sb_tag.delete();
    prev_fl = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    step(4'b0001, 16'h0003, 1, 0, 0, "post-reset frame pal3");
    step(4'b0000, 16'h0000, 0, 0, 0, "post-reset bg");
    step(4'b0000, 16'h0000, 0, 0, 0, "flush1");
    step(4'b0000, 16'h0000, 0, 0, 0, "flush2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Pipelined, parametrised per-pixel colour compositor for the VGA path.
- Resolves N_LAYERS sprite layers (ducks, dog, cursor, HUD, …) by fixed priority, maps the winning palette index to 24-bit RGB, and falls back to a sky background.
- Runs a shot-flash sequencer: after a trigger, whole frames go black, with target layers drawn solid white for hit detection.
- Sits between the sprite/object units and the VGA output pins; drives VGA_R/G/B registered.

Parameters:
- N_LAYERS, 4, number of sprite layers; layer 0 is highest priority.
- PAL_W, 4, palette index width; 2**PAL_W palette entries.
- FLASH_FRAMES, 2, frames held in flash mode per shot; legal range 1..15.

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- blank_n  in  1  0 = blanking interval; forces black output.
- frame_start  in  1  one-cycle pulse coincident with the first pixel of a frame.
- layer_on  in  N_LAYERS  per-layer hit for the current pixel.
- layer_idx  in  N_LAYERS*PAL_W  packed palette indices; layer k occupies bits [k*PAL_W +: PAL_W].
- target_mask  in  N_LAYERS  layers drawn white during flash.
- shot  in  1  one-cycle trigger pulse from the gun/mouse.
- VGA_R  out  8  red.
- VGA_G  out  8  green.
- VGA_B  out  8  blue.
- flash_active  out  1  high while the FSM is in FLASH.

Behaviour:
- Reset is asynchronous, active-low. While Reset_n = 0: VGA_R/G/B = 0, flash_active = 0, FSM = IDLE, frame counter = 0, all pipeline registers = 0.
- Pixel latency is exactly 2 cycles, from inputs sampled at edge N to RGB valid after edge N+2. blank_n, DrawX and DrawY are piped alongside the pixel data.
- Stage 1 (layer resolve):
  - Winner = lowest k with layer_on[k] = 1 and layer_idx[k] ≠ 0. Index 0 is transparent, so the pixel falls through to the next layer.
  - No winner → background.
  - Register: hit flag, winning index, the target_mask bit of the winner, and the flash state sampled this cycle.
- Stage 2 (colour):
  - blank_n = 0 → RGB = 0.
  - Flash state active → RGB = FFFFFF if hit and the winner is a target, else 000000.
  - Otherwise hit → RGB = palette[index].
  - Otherwise no hit → RGB = background.
- Background (solid): R = 3F, G = BF, B = FF (sky).
- Flash FSM, states IDLE, ARMED, FLASH:
  - IDLE: shot → ARMED.
  - ARMED: frame_start → FLASH, counter loaded with FLASH_FRAMES−1.
  - FLASH: on frame_start, counter = 0 → IDLE; otherwise counter decrements.
  - shot in ARMED or FLASH is ignored (no queueing).
  - shot and frame_start in the same cycle in IDLE → ARMED only. Flash begins on the next frame_start, so it never starts mid-frame.
  - flash_active is registered and equals (state == FLASH). Transitions on a frame_start edge affect that frame's first pixel onward.
- Arithmetic: gradient subtraction is 8-bit with no wrap. DrawX[9:3] ≤ 79, so 7F − 79 ≥ 0.
- Reset asserted mid-flash returns to IDLE immediately; the next frame renders normally.

Optional Feature:
- Macro GRADIENT_BG_EN.
- Defined: background B = 8'h7F − {1'b0, DrawX_piped[9:3]}, R = 3F, G = 00 (dusk gradient).
- Undefined: solid sky background as above; the DrawX pipeline bits may be optimised away.
- Flash and palette behaviour are identical in both builds.

Decomposition:
- Package layer_pkg holds:
  - typedef rgb_t (struct: r, g, b, 8 bits each).
  - typedef flash_state_e (IDLE, ARMED, FLASH).
  - constants SKY_RGB, FLASH_HIT_RGB, FLASH_MISS_RGB.
  - a 16-entry palette constant array plus a function pal_lookup(index) → rgb_t.
- One sub-module: layer_priority_enc, a combinational priority encoder producing hit and winning index, so it can be verified standalone.
- FSM and datapath stay in layer_compositor.

Test Plan:
- Reset priority: assert Reset_n = 0 mid-frame → RGB = 000000, flash_active = 0 immediately. Release, then set layer_on = 0 with blank_n = 1 → RGB = 3F/BF/FF exactly 2 cycles later.
- Priority/transparency: layer_on = 4'b0011, idx0 = 0, idx1 = 5 → RGB = pal[5] after 2 cycles. Then idx0 = 3 → pal[3].
- Blanking: blank_n = 0 with layer 0 hit → RGB = 000000 on the matching cycle.
- Flash sequence:
  - Pulse shot mid-frame → flash_active stays 0 until the next frame_start, then is 1 for exactly 2 frames (FLASH_FRAMES = 2).
  - During flash, target_mask = 4'b0001 with layer 0 hit → FFFFFF; layer 1 hit → 000000; background → 000000.
- Simultaneity: shot with frame_start in IDLE → flash starts one frame later. A second shot during FLASH does not extend the 2 frames.
- GRADIENT_BG_EN defined: DrawX = 0 → B = 7F. DrawX = 639 → B = 7F − 4F = 30, with R = 3F, G = 00.
